// File: rtl/audio_pkg.sv
// Shared audio-path constants and types used by the IFFT output collector
// and the input-side unpacker.
package audio_pkg;

  localparam int SIZE             = 16;
  localparam int OUTPUT_SIZE      = 512;
  localparam int SAMPLES          = 2048;
  localparam int SAMPLES_PER_WORD = OUTPUT_SIZE / SIZE;
  localparam int WORDS            = SAMPLES * SIZE / OUTPUT_SIZE;

  localparam int IDX_W  = $clog2(WORDS);
  localparam int CNT_W  = $clog2(SAMPLES);
  localparam int LANE_W = $clog2(SAMPLES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } collector_state_t;

endpackage

// File: rtl/output_word_mem.sv
// Readout word storage for the collector: one write port, per-word valid bits
// and a combinational read that masks words which have not been written yet.
module output_word_mem
  import audio_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_valid,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_index,
  input  logic [OUTPUT_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]       rd_index,
  output logic [OUTPUT_SIZE-1:0] rd_data
);

  logic [OUTPUT_SIZE-1:0] r_mem [WORDS];
  logic [WORDS-1:0]       r_valid;

  // Storage itself is never reset; the valid bits guard every read.
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_index] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (clear_valid) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  assign rd_data = r_valid[rd_index] ? r_mem[rd_index] : '0;

endmodule

// File: rtl/ifft_output_collector.sv
// Captures one 2048-sample IFFT frame (real parts) aligned on sync and packs
// it into 64 readable 512-bit words.
module ifft_output_collector
  import audio_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm,
  input  logic                   ce,
  input  logic [2*SIZE-1:0]      sample_in,
  input  logic                   sync,
  input  logic [IDX_W-1:0]       output_index,
  output logic [OUTPUT_SIZE-1:0] data_out,
  output logic                   busy,
  output logic                   done,
  output logic                   sync_err
);

  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);

  collector_state_t r_state, w_nextState;
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       w_capIdx;
  logic [OUTPUT_SIZE-1:0] r_stage;
  logic                   r_syncErr;
  logic                   w_capture;
  logic                   w_armAccept;
  logic                   w_setSyncErr;
  logic                   w_wrEn;
  logic [LANE_W-1:0]      w_lane;
  logic [IDX_W-1:0]       w_wrIndex;
  logic [OUTPUT_SIZE-1:0] w_wrData;
  logic [SIZE-1:0]        w_real;
  logic                   w_unusedImag;

  assign w_real       = sample_in[2*SIZE-1:SIZE];
  assign w_unusedImag = ^sample_in[SIZE-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // w_capIdx is the sample number being captured this cycle; a mid-frame
  // sync restarts numbering at 0.
  always_comb begin
    w_nextState  = r_state;
    w_capture    = 1'b0;
    w_capIdx     = r_count;
    w_armAccept  = 1'b0;
    w_setSyncErr = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (arm) begin
          w_armAccept = 1'b1;
          w_nextState = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (ce && sync) begin
          w_capture   = 1'b1;
          w_capIdx    = '0;
          w_nextState = CAPTURE;
        end
      end
      CAPTURE: begin
        if (ce) begin
          w_capture = 1'b1;
          if (sync && (r_count != '0)) begin
            w_setSyncErr = 1'b1;
            w_capIdx     = '0;
          end
          if (w_capIdx == LAST_SAMPLE) w_nextState = DONE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_lane    = w_capIdx[LANE_W-1:0];
  assign w_wrIndex = w_capIdx[CNT_W-1:LANE_W];
  assign w_wrEn    = w_capture && (w_lane == '1);
  assign w_wrData  = {w_real, r_stage[OUTPUT_SIZE-SIZE-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_stage <= '0;
    end else if (w_armAccept) begin
      r_count <= '0;
    end else if (w_capture) begin
      r_count                      <= w_capIdx + 1'b1;
      r_stage[w_lane*SIZE +: SIZE] <= w_real;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_syncErr <= 1'b0;
    else if (w_armAccept)  r_syncErr <= 1'b0;
    else if (w_setSyncErr) r_syncErr <= 1'b1;
  end

  output_word_mem u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_valid(w_armAccept),
    .wr_en      (w_wrEn),
    .wr_index   (w_wrIndex),
    .wr_data    (w_wrData),
    .rd_index   (output_index),
    .rd_data    (data_out)
  );

  assign busy     = (r_state == WAIT_SYNC) || (r_state == CAPTURE);
  assign done     = (r_state == DONE);
  assign sync_err = r_syncErr;

endmodule

// File: tb/tb_ifft_output_collector.sv
// Directed bench for ifft_output_collector: expected words are queued as each
// word's last sample is driven and read back through output_index.
module tb_ifft_output_collector;
  import audio_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   arm;
  logic                   ce;
  logic [2*SIZE-1:0]      sample_in;
  logic                   sync;
  logic [IDX_W-1:0]       output_index;
  logic [OUTPUT_SIZE-1:0] data_out;
  logic                   busy;
  logic                   done;
  logic                   sync_err;

  typedef struct {
    int                     idx;
    logic [OUTPUT_SIZE-1:0] word;
  } exp_t;

  exp_t                   sb[$];
  int                     checkCount = 0;
  int                     passCount  = 0;
  logic [OUTPUT_SIZE-1:0] expWord;
  logic [OUTPUT_SIZE-1:0] word0;

  ifft_output_collector dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .ce          (ce),
    .sample_in   (sample_in),
    .sync        (sync),
    .output_index(output_index),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .sync_err    (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [OUTPUT_SIZE-1:0] obs,
                       input logic [OUTPUT_SIZE-1:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock of stimulus; the imaginary half carries the inverted real part.
  task automatic applyStimulus(input logic [15:0] re, input logic s,
                               input logic c, input logic a);
    sample_in = {re, ~re};
    sync      = s;
    ce        = c;
    arm       = a;
    @(posedge clk);
    #1;
    arm  = 1'b0;
    ce   = 1'b0;
    sync = 1'b0;
  endtask

  task automatic captureSamples(input int first, input int last, input int gap,
                                input logic [15:0] pat, input int armAt,
                                input bit midCheck);
    logic [15:0] v;
    for (int k = first; k <= last; k++) begin
      v = 16'(k) ^ pat;
      applyStimulus(v, (k == 0), 1'b1, (k == armAt));
      expWord[(k % 32) * 16 +: 16] = v;
      if ((k % 32) == 31) sb.push_back('{idx: k / 32, word: expWord});
      if (midCheck && k == 31) begin
        output_index = 6'd0;
        #1;
        check("mid_word0", data_out, expWord);
        word0 = expWord;
        output_index = 6'd1;
        #1;
        check("mid_word1_invalid", data_out, '0);
      end
      if (k == armAt) begin
        check("arm_ignored_busy", busy, 1);
        output_index = 6'd0;
        #1;
        check("arm_ignored_word0", data_out, word0);
      end
      if (gap != 0 && k != SAMPLES - 1) applyStimulus(16'($urandom), 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      output_index = 6'(e.idx);
      #1;
      check(tag, data_out, e.word);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    arm          = 1'b0;
    ce           = 1'b0;
    sync         = 1'b0;
    sample_in    = '0;
    output_index = '0;
    expWord      = '0;
    word0        = '0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < WORDS; i++) begin
      output_index = 6'(i);
      #1;
      check("reset_data", data_out, '0);
    end
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sync_err", sync_err, 0);

    // Frame 1: arm coincides with a sync in IDLE, which must not be captured.
    applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b1);
    check("arm_busy", busy, 1);
    repeat (3) applyStimulus(16'hDEAD, 1'b0, 1'b1, 1'b0);
    check("wait_sync_busy", busy, 1);
    captureSamples(0, 2046, 0, 16'h0000, 500, 1'b1);
    check("f1_done_early", done, 0);
    captureSamples(2047, 2047, 0, 16'h0000, -1, 1'b0);
    check("f1_done", done, 1);
    check("f1_busy", busy, 0);
    check("f1_sync_err", sync_err, 0);
    output_index = 6'd63;
    #1;
    check("f1_w63_lane31", data_out[511:496], 16'd2047);
    checkOutput("f1_word");

    // Frame 2: ce toggles every cycle, gap cycles carry sync=1 and junk.
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    check("f2_arm_done", done, 0);
    check("f2_arm_busy", busy, 1);
    output_index = 6'd0;
    #1;
    check("f2_arm_cleared", data_out, '0);
    captureSamples(0, 2046, 1, 16'h0000, -1, 1'b0);
    check("f2_done_early", done, 0);
    captureSamples(2047, 2047, 1, 16'h0000, -1, 1'b0);
    check("f2_done", done, 1);
    checkOutput("f2_word");

    // Frame 3: second sync at count 100 restarts the frame.
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    captureSamples(0, 99, 0, 16'h1111, -1, 1'b0);
    check("f3_sync_err_before", sync_err, 0);
    sb.delete();
    captureSamples(0, 0, 0, 16'hA5A5, -1, 1'b0);
    check("f3_sync_err_set", sync_err, 1);
    check("f3_busy", busy, 1);
    captureSamples(1, 2046, 0, 16'hA5A5, -1, 1'b0);
    check("f3_done_early", done, 0);
    captureSamples(2047, 2047, 0, 16'hA5A5, -1, 1'b0);
    check("f3_done", done, 1);
    check("f3_sync_err_sticky", sync_err, 1);
    checkOutput("f3_word");

    // Frame 4: reset asserted mid-capture after a sync error.
    applyStimulus(16'h0000, 1'b0, 1'b0, 1'b1);
    check("f4_arm_clears_sync_err", sync_err, 0);
    captureSamples(0, 39, 0, 16'h0F0F, -1, 1'b0);
    captureSamples(0, 35, 0, 16'h3C3C, -1, 1'b0);
    check("f4_sync_err", sync_err, 1);
    output_index = 6'd0;
    #1;
    check("f4_word0_before_reset", data_out, sb[sb.size() - 1].word);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("f4_reset_busy", busy, 0);
    check("f4_reset_sync_err", sync_err, 0);
    check("f4_reset_done", done, 0);
    check("f4_reset_word0", data_out, '0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) begin
      output_index = 6'(i);
      #1;
      check("f4_after_reset_data", data_out, '0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
